// File: rtl/sr_imem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM encodings,
// the default load command byte and the NOP returned for unmapped fetches.
package sr_imem_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE = 3'd0,
    LDR_LEN0 = 3'd1,
    LDR_LEN1 = 3'd2,
    LDR_DATA = 3'd3,
    LDR_DONE = 3'd4
  } ldr_state_t;

  localparam logic [7:0]  LDR_START_BYTE = 8'hA5;
  localparam logic [31:0] RV_NOP         = 32'h0000_0013;  // addi x0,x0,0

endpackage

// File: rtl/sr_imem_loader_ram.sv
// DEPTH x 32 instruction array: synchronous write, asynchronous read.
// No reset on the array so its contents survive a loader reset.
module sr_imem_ram #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Write port: a word written at an edge is readable right after it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sr_imem_loader.sv
// Instruction memory with a byte-stream program loader.
// Stream format: START_BYTE, count[7:0], count[15:8], then count words as
// little-endian byte groups. The core is held in reset during a load.
// Handshake: a byte transfers on a rising edge where rx_valid & rx_ready;
// rx_ready is low only in the single DONE cycle, so a word is never stalled.
module sr_imem_loader
  import sr_imem_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 6,
  parameter logic [7:0] START_BYTE = LDR_START_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] im_addr,
  output logic [31:0] im_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  ldr_state_t            state;
  logic [15:0]           count;
  logic [15:0]           widx;
  logic [1:0]            lane;
  logic [23:0]           lane_buf;

  logic                  accept;
  logic                  idx_ok;
  logic                  word_fire;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  addr_ok;

  assign accept    = rx_valid & rx_ready;
  // Out-of-range word indices are dropped, never aliased onto low addresses.
  assign idx_ok    = (widx >> ADDR_WIDTH) == 16'd0;
  assign word_fire = accept && (state == LDR_DATA) && (lane == 2'd3);
  assign we        = word_fire & idx_ok & ~rst;
  assign waddr     = widx[ADDR_WIDTH-1:0];
  assign wdata     = {rx_data, lane_buf};

  sr_imem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (im_addr[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

  // Fetches beyond the array return a NOP so a runaway pc stays harmless.
  assign addr_ok = (im_addr >> ADDR_WIDTH) == 32'd0;
  assign im_data = addr_ok ? rdata : RV_NOP;

  // Loader FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LDR_IDLE;
      rx_ready  <= 1'b1;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      count     <= 16'd0;
      widx      <= 16'd0;
      lane      <= 2'd0;
      lane_buf  <= 24'd0;
    end else begin
      case (state)
        LDR_IDLE: begin
          if (accept && rx_data == START_BYTE) begin
            state    <= LDR_LEN0;
            cpu_hold <= 1'b1;
            load_err <= 1'b0;
          end
        end
        LDR_LEN0: begin
          if (accept) begin
            count[7:0] <= rx_data;
            state      <= LDR_LEN1;
          end
        end
        LDR_LEN1: begin
          if (accept) begin
            count[15:8] <= rx_data;
            widx        <= 16'd0;
            lane        <= 2'd0;
            if ({rx_data, count[7:0]} == 16'd0) begin
              state     <= LDR_DONE;
              rx_ready  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state <= LDR_DATA;
            end
          end
        end
        LDR_DATA: begin
          if (accept) begin
            if (lane == 2'd3) begin
              lane <= 2'd0;
              widx <= widx + 16'd1;
              if (!idx_ok) load_err <= 1'b1;
              if (widx == count - 16'd1) begin
                state     <= LDR_DONE;
                rx_ready  <= 1'b0;
                load_done <= 1'b1;
              end
            end else begin
              lane_buf[{lane, 3'b000} +: 8] <= rx_data;
              lane <= lane + 2'd1;
            end
          end
        end
        LDR_DONE: begin
          state     <= LDR_IDLE;
          rx_ready  <= 1'b1;
          cpu_hold  <= 1'b0;
          load_done <= 1'b0;
        end
        default: begin
          state <= LDR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sr_imem_loader.md
Name: sr_imem_loader

Overview:
- Instruction memory sitting directly upstream of the CPU core.
- Serves the core's combinational instruction fetch: word address in, instruction word out, same cycle.
- Also accepts a byte-stream program image over a valid/ready port, for example from a UART receiver.
- Holds the core in reset while a load is in progress.

Parameters:
- ADDR_WIDTH, 6, log2 of memory depth in 32-bit words. DEPTH = 2**ADDR_WIDTH.
- START_BYTE, 8'hA5, command byte that begins a load.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  load stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte. Transfer happens when rx_valid & rx_ready at a rising edge.
- im_addr  in  32  fetch word address (core's pc>>2)
- im_data  out  32  fetched instruction, combinational from im_addr
- cpu_hold  out  1  high while loading; drives the core's reset
- load_done  out  1  one-cycle pulse when a load completes
- load_err  out  1  sticky: the load image was larger than DEPTH

Behaviour:
- Reset values:
  - state=IDLE, rx_ready=1, cpu_hold=0, load_done=0, load_err=0.
  - Byte and word counters cleared.
  - Memory array is NOT reset; contents survive rst.
- Read port:
  - im_data = mem[im_addr[ADDR_WIDTH-1:0]] when im_addr < DEPTH, else 32'h0000_0013 (addi x0,x0,0).
  - Purely combinational.
  - A word written at edge k is visible on im_data from edge k onward.
- States: IDLE, LEN0, LEN1, DATA, DONE.
- IDLE:
  - Accepted byte == START_BYTE: go to LEN0, set cpu_hold=1 on the same edge, clear load_err.
  - Any other byte: consumed and ignored; stay in IDLE.
- LEN0: accepted byte -> count[7:0]; go to LEN1.
- LEN1:
  - Accepted byte -> count[15:8].
  - Word count 0: go to DONE.
  - Otherwise: clear word index and byte lane, go to DATA.
- DATA:
  - Bytes are assembled little-endian: the first byte of each word is bits [7:0].
  - On acceptance of the 4th byte, write {byte3,byte2,byte1,byte0} to mem[word index] on that edge and increment the word index.
  - If the word index >= DEPTH, the write is suppressed and load_err is set; the stream is still fully consumed.
  - After word count-1 is written: go to DONE.
- DONE (exactly one cycle):
  - rx_ready=0, load_done=1, cpu_hold stays 1.
  - Next edge: go to IDLE with cpu_hold=0.
- rx_ready = 1 in all states except DONE. The block never stalls mid-word.
- rx_valid low in any state: hold state; no partial-word change.
- Word index and count are 16 bits wide. No wrap on the memory address; out-of-range indices are dropped, never aliased.
- rst during LEN0/LEN1/DATA/DONE:
  - Return to IDLE with cpu_hold=0; no load_done.
  - Words already written remain; a partial word is discarded.
- START_BYTE received during LEN0/LEN1/DATA: treated as data, not a restart.

Decomposition:
- Shared header sr_cpu.vh gains:
  - loader state encodings (LDR_IDLE..LDR_DONE)
  - `LDR_START_BYTE default
  - `RV_NOP encoding 32'h0000_0013
- One sub-module, sr_imem_ram: DEPTH x 32 array, synchronous write (we, waddr, wdata), asynchronous read (raddr, rdata).
- Out-of-range NOP substitution, FSM, byte lane shifter and counters live in sr_imem_loader.

Test Plan:
- Reset, then no stimulus: rx_ready=1, cpu_hold=0, load_done=0, load_err=0.
- Stream A5 02 00 13 05 10 00 93 05 20 00:
  - cpu_hold=1 from the edge A5 is accepted.
  - mem[0]=32'h00100513, mem[1]=32'h00200593.
  - One-cycle load_done with rx_ready=0, then cpu_hold=0.
  - im_addr=0 gives 00100513; im_addr=1 gives 00200593.
- Stream A5 00 00: LEN1 -> DONE directly; load_done pulse; memory unchanged; cpu_hold high for exactly 3 cycles after the A5 edge.
- ADDR_WIDTH=2, load 5 words (count 05 00, 20 data bytes):
  - Words 0-3 written.
  - Fifth word dropped; load_err=1 and stays 1 through IDLE.
  - A new A5 clears load_err.
- Garbage 00 FF 13 in IDLE, then a valid 1-word load with rx_valid toggling every other cycle: garbage ignored, word written correctly, no extra writes.
- rst asserted after 2 data bytes of word 1 in a 2-word load:
  - IDLE, cpu_hold=0, no load_done.
  - Word 0 retained.
  - im_addr=64 (>= DEPTH) returns 32'h00000013.
